jtag_scan_master: RTL and testbench
===================================

# jtag_scan_master

Initiator side of the JTAG link. The block generates TCK/TMS/TDI from the system clock and samples TDO, and it runs complete IR scans, DR scans and TAP resets on request. Its job is to drive the on-chip JTAG data registers, or external TAPs, from fabric logic such as test harnesses, loopback self-test and debug bridges. The parallel side is a start/done handshake in the sysclk domain.

## Interface
- `bits`, 32: maximum scan length and width of `d`/`q`; legal range 1..256.
- `clkdiv`, 4: sysclk cycles per TCK half-period; ≥1.

- `sysclk` in 1: system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous reset, active low.
- `start` in 1: request pulse; sampled only while `busy`=0.
- `op` in 2: operation. 0 = DR scan, 1 = IR scan, 2 = TAP reset, 3 = reserved (treated as TAP reset).
- `len` in $clog2(bits+1): number of bits to shift. 0 or >`bits` means `bits`.
- `d` in `bits`: data to shift out, bit 0 first.
- `q` out `bits`: captured TDO bits, bit 0 = first captured.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion strobe.
- `tck` out 1: JTAG clock.
- `tms` out 1: JTAG mode select.
- `tdi` out 1: JTAG data to target.
- `tdo` in 1: JTAG data from target. It is synchronous to `sysclk` and needs no synchronizer here.

## Operation
- Idle: `tck`=0, `tms`=0, `tdi`=0. The TAP is assumed parked in Run-Test/Idle.
- On `start` with `busy`=0:
  - latch `op`, the effective length L, and `d`;
  - clear `q`;
  - assert `busy` on the next cycle.
- Each TMS/TDI value occupies one slot = `clkdiv` cycles with `tck`=0, then `clkdiv` cycles with `tck`=1.
- `tms`/`tdi` change only at slot start, which is the TCK falling edge or the first slot.
- Slot TMS sequences:
  - DR scan: 1, 0, 0 (Select-DR, Capture-DR, Shift-DR), then L shift slots, then 1, 0 (Update-DR, Idle). Total L+5 slots.
  - In shift slots, TMS=0 for the first L−1 slots and 1 for the last slot (exit to Exit1).
  - IR scan: 1, 1, 0, 0, then L shift slots as above, then 1, 0. Total L+6 slots.
  - TAP reset: 1, 1, 1, 1, 1, 0. Total 6 slots, ending in Run-Test/Idle. `q` is unchanged apart from the clear at start.
- `tdi`:
  - Shift slot k (k = 0..L−1) drives `d[k]`.
  - All non-shift slots drive 0.
- `tdo` sampling:
  - Sampled on the cycle where `tck` goes 0→1.
  - In shift slot k, the sample is written to `q[k]`.
  - Samples in non-shift slots are discarded.
  - `q[bits-1:L]` stays 0.
- `q` is updated only by shift-slot samples and holds its value after `done` until the next `start`.
- Minimum state machine states: IDLE, PRE (TMS preamble), SHIFT, POST (TMS postamble), DONE. A half-period counter and a bit counter sit alongside.

## Timing
- Reset values: `tck`=0, `tms`=0, `tdi`=0, `busy`=0, `done`=0, `q`=0.
- Cycle S is the cycle `start` is sampled high. `tck`=0 for slot 0 starts at S+1, and `busy`=1 from S+1.
- An operation with N slots has its last `tck`-high cycle at S+2·N·`clkdiv`. On the next cycle:
  - `done`=1 for exactly one cycle;
  - `busy`=0 and `tck`=0.
- DR scan with L=32 and `clkdiv`=4: `done` at S+1+296.
- `start` while `busy`=1 is ignored. `start` in the `done` cycle is accepted, and `busy` is then 1 again on the next cycle.
- Inputs `op`/`len`/`d` are sampled only at S; changes during an operation have no effect.
- L=1: the single shift slot carries TMS=1.
- `reset_n` low mid-operation: all outputs go to their reset values immediately. The TAP state is then undefined, and the user issues `op`=2 before further scans.

## Test plan
- TAP reset, `clkdiv`=1: TMS sequence 1,1,1,1,1,0 on six `tck` rising edges; `done` at S+13; `q`=0.
- DR scan, L=32, `d`=0xDEADBEEF, bench TAP model with a 32-bit loopback register preloaded with 0x12345678: captured `q`=0x12345678; TAP DR=0xDEADBEEF after Update; `busy` high for exactly 296 cycles (`clkdiv`=4).
- IR scan, L=5, `d`=0x13: TAP IR updates to 0x13; TMS 1,1,0,0,0,0,0,0,1,1,0; `q[31:5]`=0.
- Length edges, `bits`=32:
  - `len`=1: one shift slot with TMS=1.
  - `len`=0: 32 bits shifted.
  - `len`=40: clamped to 32 bits.
- Handshake: `start` held high continuously. Back-to-back operations begin in the cycle after each `done`, with no gap slots, and extra `start` pulses while busy are ignored.
- Reset mid-scan: assert `reset_n`=0 during SHIFT. All outputs are at reset values in the same cycle. After release, `op`=2 followed by a DR scan returns correct data.

Source files
------------

// File: rtl/jtag_scan_master.sv
// JTAG scan initiator: runs DR/IR scans and TAP resets,
// generating TCK/TMS/TDI from sysclk and capturing TDO.
module jtag_scan_master #(
  parameter int bits   = 32,
  parameter int clkdiv = 4
) (
  input  logic                      sysclk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [$clog2(bits+1)-1:0] len,
  input  logic [bits-1:0]           d,
  output logic [bits-1:0]           q,
  output logic                      busy,
  output logic                      done,
  output logic                      tck,
  output logic                      tms,
  output logic                      tdi,
  input  logic                      tdo
);
  localparam int LW = $clog2(bits+1);
  localparam int BW = (bits > 1) ? $clog2(bits) : 1;
  localparam int HW = (clkdiv > 1) ? $clog2(clkdiv) : 1;

  typedef enum logic [2:0] {
    IDLE, PRE, SHIFT, POST, DONE
  } state_t;

  state_t          state;
  logic [1:0]      op_r;
  logic [bits-1:0] d_r;
  logic [BW-1:0]   last_r;
  logic [BW-1:0]   bit_idx;
  logic [BW-1:0]   bit_nx;
  logic [BW-1:0]   eff_last;
  logic [2:0]      slot;
  logic [2:0]      slot_nx;
  logic [2:0]      pre_last;
  logic [HW-1:0]   hc;
  logic            half_end;

  // Index of the last shift slot; 0 or oversize means full width.
  assign eff_last = (len == '0 || len > LW'(bits))
                  ? BW'(bits - 1)
                  : BW'(len - 1'b1);

  assign bit_nx   = bit_idx + 1'b1;
  assign slot_nx  = slot + 1'b1;
  assign half_end = (hc == HW'(clkdiv - 1));
  assign pre_last = op_r[1] ? 3'd5 :
                    (op_r[0] ? 3'd3 : 3'd2);

  function automatic logic pre_tms(
    input logic [1:0] o,
    input logic [2:0] s
  );
    logic t;
    t = 1'b0;
    unique case (1'b1)
      o[1]:           t = (s < 3'd5);
      (o == 2'b01):   t = (s < 3'd2);
      (o == 2'b00):   t = (s == 3'd0);
    endcase
    return t;
  endfunction

  // Slot sequencer: TCK halves, per-slot TMS/TDI, TDO capture.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_r    <= '0;
      d_r     <= '0;
      last_r  <= '0;
      bit_idx <= '0;
      slot    <= '0;
      hc      <= '0;
      q       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tck     <= 1'b0;
      tms     <= 1'b0;
      tdi     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            state   <= PRE;
            op_r    <= op;
            d_r     <= d;
            last_r  <= eff_last;
            q       <= '0;
            busy    <= 1'b1;
            slot    <= '0;
            bit_idx <= '0;
            hc      <= '0;
            tck     <= 1'b0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
          end
        end
        default: begin
          if (!half_end) begin
            hc <= hc + 1'b1;
          end else begin
            hc <= '0;
            if (!tck) begin
              tck <= 1'b1;
              if (state == SHIFT)
                q[bit_idx] <= tdo;
            end else begin
              tck <= 1'b0;
              tdi <= 1'b0;
              unique case (state)
                PRE: begin
                  if (slot != pre_last) begin
                    slot <= slot_nx;
                    tms  <= pre_tms(op_r, slot_nx);
                  end else if (op_r[1]) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    tms   <= 1'b0;
                  end else begin
                    state   <= SHIFT;
                    bit_idx <= '0;
                    tms     <= (last_r == '0);
                    tdi     <= d_r[0];
                  end
                end
                SHIFT: begin
                  if (bit_idx == last_r) begin
                    state <= POST;
                    slot  <= '0;
                    tms   <= 1'b1;
                  end else begin
                    bit_idx <= bit_nx;
                    tms     <= (bit_nx == last_r);
                    tdi     <= d_r[bit_nx];
                  end
                end
                POST: begin
                  if (slot == 3'd0) begin
                    slot <= 3'd1;
                    tms  <= 1'b0;
                  end else begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    tms   <= 1'b0;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: behavioural TAP target plus
// slot-level reference of scan sequences and captured data.
module tb_jtag_scan_master;
  localparam int BITS = 32;
  localparam int CD   = 4;

  logic        sysclk  = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [1:0]  op      = '0;
  logic [5:0]  len     = '0;
  logic [31:0] d       = '0;
  logic [31:0] q;
  logic        busy;
  logic        done;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        tdo     = 1'b0;

  int checks = 0;
  int errors = 0;

  jtag_scan_master #(.bits(BITS), .clkdiv(CD)) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .len     (len),
    .d       (d),
    .q       (q),
    .busy    (busy),
    .done    (done),
    .tck     (tck),
    .tms     (tms),
    .tdi     (tdi),
    .tdo     (tdo)
  );

  always #5 sysclk = ~sysclk;

  typedef enum logic [3:0] {
    TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR,
    SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR
  } tap_t;

  tap_t        st     = RTI;
  logic [31:0] tap_dr = 32'h12345678;
  logic [31:0] dr_sr  = '0;
  logic [4:0]  tap_ir = 5'd1;
  logic [4:0]  ir_sr  = '0;
  logic        prev_tck = 1'b0;
  logic [1:0]  slots[$];

  function automatic tap_t tap_next(input tap_t s, input logic m);
    tap_t n;
    case (s)
      TLR:  n = m ? TLR  : RTI;
      RTI:  n = m ? SDS  : RTI;
      SDS:  n = m ? SIS  : CDR;
      CDR:  n = m ? E1DR : SHDR;
      SHDR: n = m ? E1DR : SHDR;
      E1DR: n = m ? UDR  : PDR;
      PDR:  n = m ? E2DR : PDR;
      E2DR: n = m ? UDR  : SHDR;
      UDR:  n = m ? SDS  : RTI;
      SIS:  n = m ? TLR  : CIR;
      CIR:  n = m ? E1IR : SHIR;
      SHIR: n = m ? E1IR : SHIR;
      E1IR: n = m ? UIR  : PIR;
      PIR:  n = m ? E2IR : PIR;
      E2IR: n = m ? UIR  : SHIR;
      default: n = m ? SDS : RTI;
    endcase
    return n;
  endfunction

  // Target TAP: acts on TCK rise, drives TDO after TCK fall.
  always @(negedge sysclk) begin
    if (tck && !prev_tck) begin
      slots.push_back({tms, tdi});
      case (st)
        CDR:  dr_sr = tap_dr;
        SHDR: dr_sr = {tdi, dr_sr[31:1]};
        UDR:  tap_dr = dr_sr;
        CIR:  ir_sr = 5'd1;
        SHIR: ir_sr = {tdi, ir_sr[4:1]};
        UIR:  tap_ir = ir_sr;
        TLR:  tap_ir = 5'd1;
        default: ;
      endcase
      st = tap_next(st, tms);
    end else if (!tck && prev_tck) begin
      tdo = (st == SHDR) ? dr_sr[0] :
            (st == SHIR) ? ir_sr[0] : 1'b0;
    end
    prev_tck = tck;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_tck"},  32'(tck),  0);
    chk({tag, "_tms"},  32'(tms),  0);
    chk({tag, "_tdi"},  32'(tdi),  0);
  endtask

  task automatic do_op(input logic [1:0] o,
                       input logic [5:0] l,
                       input logic [31:0] dv);
    int          nl;
    int          ns;
    int          bc;
    int          bad;
    logic [31:0] cap;
    logic [31:0] eq;
    logic [31:0] er;
    logic [4:0]  er_ir;
    logic [4:0]  capir;
    logic [1:0]  exp_s[$];
    capir = 5'd1;
    nl = (l == 0 || l > 32) ? 32 : int'(l);
    if (o[1]) begin
      for (int i = 0; i < 6; i++)
        exp_s.push_back({(i < 5), 1'b0});
      ns = 6;
    end else begin
      exp_s.push_back(2'b10);
      if (o[0]) exp_s.push_back(2'b10);
      exp_s.push_back(2'b00);
      exp_s.push_back(2'b00);
      for (int k = 0; k < nl; k++)
        exp_s.push_back({(k == nl - 1), dv[k]});
      exp_s.push_back(2'b10);
      exp_s.push_back(2'b00);
      ns = o[0] ? nl + 6 : nl + 5;
    end
    @(negedge sysclk);
    start = 1'b1;
    op    = o;
    len   = l;
    d     = dv;
    cap   = tap_dr;
    slots.delete();
    @(posedge sysclk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    len   = 6'($urandom);
    d     = $urandom;
    chk("busy_s1",  32'(busy), 1);
    chk("tck_s1",   32'(tck),  0);
    chk("done_s1",  32'(done), 0);
    chk("q_clear",  q,         0);
    bc = 1;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(posedge sysclk);
      #1;
      if (busy) bc++;
    end
    chk("done_seen",   32'(done), 1);
    chk("busy_cycles", bc, 2 * ns * CD);
    chk_idle_outs("end");
    eq = '0;
    if (o == 2'd0) begin
      for (int k = 0; k < nl; k++) eq[k] = cap[k];
    end else if (o == 2'd1) begin
      for (int k = 0; k < nl; k++)
        eq[k] = (k < 5) ? capir[k] : dv[k - 5];
    end
    chk("q_data", q, eq);
    chk("slot_count", slots.size(), exp_s.size());
    bad = 0;
    for (int i = 0; i < exp_s.size() && i < slots.size(); i++)
      if (slots[i] !== exp_s[i]) bad++;
    chk("slot_seq", bad, 0);
    chk("tap_parked", 32'(st), 32'(RTI));
    if (o == 2'd0) begin
      for (int i = 0; i < 32; i++)
        er[i] = (i + nl < 32) ? cap[i + nl] : dv[i + nl - 32];
      chk("tap_dr", tap_dr, er);
    end else if (o == 2'd1) begin
      for (int i = 0; i < 5; i++)
        er_ir[i] = (i + nl < 5) ? capir[i + nl] : dv[i + nl - 5];
      chk("tap_ir", 32'(tap_ir), 32'(er_ir));
    end else begin
      chk("tap_ir_rst", 32'(tap_ir), 1);
    end
    @(posedge sysclk);
    #1;
    chk("done_pulse", 32'(done), 0);
    chk("busy_after", 32'(busy), 0);
  endtask

  initial begin
    int k;
    #1;
    chk_idle_outs("rst");
    chk("rst_done", 32'(done), 0);
    chk("rst_q", q, 0);
    repeat (2) @(negedge sysclk);
    reset_n = 1'b1;
    @(posedge sysclk);
    #1;
    chk_idle_outs("rel");

    do_op(2'd2, 6'd0, $urandom);
    do_op(2'd0, 6'd32, 32'hDEADBEEF);
    chk("dr_loop", tap_dr, 32'hDEADBEEF);
    do_op(2'd1, 6'd5, 32'h13);
    chk("ir_13", 32'(tap_ir), 32'h13);
    chk("ir_q", q, 32'h1);
    do_op(2'd0, 6'd1, $urandom);
    do_op(2'd0, 6'd0, $urandom);
    do_op(2'd0, 6'd40, $urandom);
    do_op(2'd3, 6'd7, $urandom);
    for (int i = 0; i < 12; i++)
      do_op(2'($urandom_range(0, 3)),
            6'($urandom_range(0, 40)),
            $urandom);

    @(negedge sysclk);
    start = 1'b1;
    op    = 2'd2;
    len   = '0;
    d     = '0;
    slots.delete();
    @(posedge sysclk);
    #1;
    k = 1;
    while (k < 200 && !done) begin
      @(posedge sysclk);
      #1;
      k++;
    end
    chk("hs_done1", k, 2 * 6 * CD + 1);
    @(posedge sysclk);
    #1;
    chk("hs_busy2", 32'(busy), 1);
    chk("hs_tck2",  32'(tck),  0);
    chk("hs_done2_low", 32'(done), 0);
    k = 1;
    while (k < 200 && !done) begin
      @(posedge sysclk);
      #1;
      k++;
    end
    start = 1'b0;
    chk("hs_done2", k, 2 * 6 * CD + 1);
    chk("hs_slots", slots.size(), 12);
    k = 0;
    for (int i = 0; i < 12 && i < slots.size(); i++)
      if (slots[i] !== {(i % 6 < 5), 1'b0}) k++;
    chk("hs_seq", k, 0);
    @(posedge sysclk);
    #1;
    chk("hs_stop", 32'(busy), 0);

    @(negedge sysclk);
    start = 1'b1;
    op    = 2'd0;
    len   = '0;
    d     = $urandom;
    @(posedge sysclk);
    #1;
    start = 1'b0;
    repeat (60) @(posedge sysclk);
    @(negedge sysclk);
    reset_n = 1'b0;
    #1;
    chk_idle_outs("mid");
    chk("mid_done", 32'(done), 0);
    chk("mid_q", q, 0);
    repeat (2) @(negedge sysclk);
    reset_n = 1'b1;
    @(posedge sysclk);
    #1;
    chk("mid_rel", 32'(busy), 0);
    do_op(2'd2, 6'd0, 32'h0);
    do_op(2'd0, 6'd32, $urandom);
    do_op(2'd0, 6'd32, 32'hA5A5_0F0F);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
